// File: rtl/rv32im_dmem_resp.sv
// ============================================================================
// Module   : rv32im_dmem_resp
// Brief    : Data-memory responder for the LSU load/store interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif
`ifndef LSU_OPCODE_LB
`define LSU_OPCODE_LB  4'h0
`define LSU_OPCODE_LH  4'h1
`define LSU_OPCODE_LW  4'h2
`define LSU_OPCODE_LBU 4'h4
`define LSU_OPCODE_LHU 4'h5
`define LSU_OPCODE_SB  4'h8
`define LSU_OPCODE_SH  4'h9
`define LSU_OPCODE_SW  4'hA
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module rv32im_dmem_resp #(
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [`LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
  input  logic [`API_ADDR_WIDTH-1:0]   addr_mem_i,
  input  logic [`API_DATA_WIDTH-1:0]   val_memwr_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [`API_DATA_WIDTH-1:0]   val_memrd_o,
  output logic                         rsp_err_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam int c_AW  = `API_ADDR_WIDTH;
  localparam logic [`API_ADDR_WIDTH-1:0] c_ADDR_LIMIT = c_AW'(4 * MEM_DEPTH_WORDS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t                       r_state;
  logic                         r_err;
  logic [`API_DATA_WIDTH-1:0]   r_rdata;
  logic [`API_DATA_WIDTH-1:0]   r_mem [MEM_DEPTH_WORDS];

  logic                         w_accept;
  logic [1:0]                   w_off;
  logic [IDX_W-1:0]             w_idx;
  logic [4:0]                   w_shamt;
  logic                         w_oor;
  logic                         w_is_load;
  logic                         w_is_store;
  logic                         w_illegal;
  logic                         w_misalign;
  logic                         w_fault;
  logic [3:0]                   w_be;
  logic [`API_DATA_WIDTH-1:0]   w_wdata;
  logic [`API_DATA_WIDTH-1:0]   w_rdata;

  // Ready never depends on req_valid_i, so the upstream handshake stays loop-free.
  assign req_ready_o = (r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready_i);
  assign w_accept    = req_valid_i & req_ready_o;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_err_o   = r_err;
  assign val_memrd_o = r_rdata;

  assign w_off   = addr_mem_i[1:0];
  assign w_idx   = addr_mem_i[IDX_W+1:2];
  assign w_shamt = {w_off, 3'b000};
  assign w_oor   = (addr_mem_i >= c_ADDR_LIMIT);
  assign w_wdata = val_memwr_i << w_shamt;
  assign w_rdata = r_mem[w_idx] >> w_shamt;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    case (lsu_opcode_i)
      `LSU_OPCODE_LB, `LSU_OPCODE_LBU: w_is_load = 1'b1;
      `LSU_OPCODE_LH, `LSU_OPCODE_LHU: begin
        w_is_load  = 1'b1;
        w_misalign = w_off[0];
      end
      `LSU_OPCODE_LW: begin
        w_is_load  = 1'b1;
        w_misalign = (w_off != 2'b00);
      end
      `LSU_OPCODE_SB: begin
        w_is_store = 1'b1;
        w_be       = 4'b0001 << w_off;
      end
      `LSU_OPCODE_SH: begin
        w_is_store = 1'b1;
        w_misalign = w_off[0];
        w_be       = 4'b0011 << w_off;
      end
      `LSU_OPCODE_SW: begin
        w_is_store = 1'b1;
        w_misalign = (w_off != 2'b00);
        w_be       = 4'b1111;
      end
      default: w_illegal = 1'b1;
    endcase
    w_fault = w_illegal | w_misalign | w_oor;
  end

  // Array is not reset; writes land on the accept edge so a following load sees them.
  always_ff @(posedge clk_i) begin
    if (w_accept && w_is_store && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_state <= S_RESP;
      r_err   <= w_fault;
      r_rdata <= (w_is_load && !w_fault) ? w_rdata : '0;
    end else if (rsp_ready_i) begin
      r_state <= S_IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32im_dmem_resp.sv
// ============================================================================
// Module   : tb_rv32im_dmem_resp
// Brief    : Directed self-checking bench for rv32im_dmem_resp.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif
`ifndef LSU_OPCODE_LB
`define LSU_OPCODE_LB  4'h0
`define LSU_OPCODE_LH  4'h1
`define LSU_OPCODE_LW  4'h2
`define LSU_OPCODE_LBU 4'h4
`define LSU_OPCODE_LHU 4'h5
`define LSU_OPCODE_SB  4'h8
`define LSU_OPCODE_SH  4'h9
`define LSU_OPCODE_SW  4'hA
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module tb_rv32im_dmem_resp;

  localparam int MEM_DEPTH_WORDS = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  lsu_opcode;
  logic [31:0] addr_mem;
  logic [31:0] val_memwr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] val_memrd;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  rv32im_dmem_resp #(.MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .lsu_opcode_i (lsu_opcode),
    .addr_mem_i   (addr_mem),
    .val_memwr_i  (val_memwr),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .val_memrd_o  (val_memrd),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request with rsp_ready held high; response is checked one cycle later.
  task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_e);
    req_valid  = 1'b1;
    lsu_opcode = op;
    addr_mem   = addr;
    val_memwr  = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    check_val({tag, ".data"},  val_memrd, exp_rd);
    check_val({tag, ".err"},   {31'd0, rsp_err}, {31'd0, exp_e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    lsu_opcode = '0; addr_mem = '0; val_memwr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst.err",   {31'd0, rsp_err},   32'd0);
    check_val("rst.data",  val_memrd,          32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst.ready", {31'd0, req_ready}, 32'd1);

    // Byte-lane stores
    txn("sw10", `LSU_OPCODE_SW, 32'h10, 32'h11223344, 32'h0, 1'b0);
    txn("sb12", `LSU_OPCODE_SB, 32'h12, 32'h000000AA, 32'h0, 1'b0);
    txn("sh10", `LSU_OPCODE_SH, 32'h10, 32'h0000BEEF, 32'h0, 1'b0);
    txn("lw10", `LSU_OPCODE_LW, 32'h10, 32'h0,        32'h11AABEEF, 1'b0);

    // Shifted loads
    txn("sw20",  `LSU_OPCODE_SW,  32'h20, 32'h80FF7F01, 32'h0, 1'b0);
    txn("lb23",  `LSU_OPCODE_LB,  32'h23, 32'h0, 32'h00000080, 1'b0);
    txn("lhu22", `LSU_OPCODE_LHU, 32'h22, 32'h0, 32'h000080FF, 1'b0);
    txn("lbu20", `LSU_OPCODE_LBU, 32'h20, 32'h0, 32'h80FF7F01, 1'b0);
    txn("lh21",  `LSU_OPCODE_LH,  32'h21, 32'h0, 32'h0,        1'b1);

    // Faults must not disturb the array
    txn("sh21",  `LSU_OPCODE_SH, 32'h21, 32'h0000FFFF, 32'h0, 1'b1);
    txn("lw22",  `LSU_OPCODE_LW, 32'h22, 32'h0,        32'h0, 1'b1);
    txn("swoor", `LSU_OPCODE_SW, 32'h1020, 32'hDEADBEEF, 32'h0, 1'b1);
    txn("sw4k",  `LSU_OPCODE_SW, 4*MEM_DEPTH_WORDS, 32'hDEADBEEF, 32'h0, 1'b1);
    txn("illop", 4'h3,           32'h20, 32'hDEADBEEF, 32'h0, 1'b1);
    txn("lw20",  `LSU_OPCODE_LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0);

    // Last valid word
    txn("swtop", `LSU_OPCODE_SW,  32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    txn("sbtop", `LSU_OPCODE_SB,  32'hFFF, 32'h00000012, 32'h0, 1'b0);
    txn("lwtop", `LSU_OPCODE_LW,  32'hFFC, 32'h0, 32'h12FEF00D, 1'b0);
    txn("lbutop",`LSU_OPCODE_LBU, 32'hFFE, 32'h0, 32'h000012FE, 1'b0);
    @(posedge clk); #1;
    check_val("idle.valid", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: second request held off until rsp_ready rises
    rsp_ready = 1'b0;
    req_valid = 1'b1; lsu_opcode = `LSU_OPCODE_LW; addr_mem = 32'h10; val_memwr = '0;
    @(posedge clk); #1;
    lsu_opcode = `LSU_OPCODE_LBU; addr_mem = 32'h23;
    for (int c = 0; c < 3; c++) begin
      check_val("bp.ready", {31'd0, req_ready}, 32'd0);
      check_val("bp.valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp.data",  val_memrd, 32'h11AABEEF);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp.ready1", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("bp2.valid", {31'd0, rsp_valid}, 32'd1);
    check_val("bp2.data",  val_memrd, 32'h00000080);
    @(posedge clk); #1;

    // Streaming: alternating SW/LW back to back
    for (int k = 0; k < 4; k++) begin
      txn("st.sw", `LSU_OPCODE_SW, 32'h30, 32'hA5A50000 + k, 32'h0, 1'b0);
      txn("st.lw", `LSU_OPCODE_LW, 32'h30, 32'h0, 32'hA5A50000 + k, 1'b0);
    end
    @(posedge clk); #1;

    // Reset while a response is stalled
    rsp_ready = 1'b0;
    req_valid = 1'b1; lsu_opcode = `LSU_OPCODE_LW; addr_mem = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("mr.valid", {31'd0, rsp_valid}, 32'd1);
    check_val("mr.data",  val_memrd, 32'h80FF7F01);
    #2 rst_n = 1'b0;
    #1;
    check_val("mr.valid0", {31'd0, rsp_valid}, 32'd0);
    check_val("mr.data0",  val_memrd, 32'd0);
    check_val("mr.err0",   {31'd0, rsp_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("mr.ready", {31'd0, req_ready}, 32'd1);
    check_val("mr.idle",  {31'd0, rsp_valid}, 32'd0);
    txn("mr.lw", `LSU_OPCODE_LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
